// File: rtl/simd_alu_req_sched_if.sv
// Signal bundle for the two-requester SIMD ALU scheduler: request fabric, ALU port and response port.
// The slave modport is the scheduler's view; the master modport is the surrounding fabric and ALU.
interface simd_alu_req_sched_if #(
    parameter int DATA_W = 256,
    parameter int OPC_W  = 4,
    parameter int TAG_W  = 4
);
    localparam int FLG_W = DATA_W / 8;

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [2*OPC_W-1:0]  req_opcode;
    logic [2*TAG_W-1:0]  req_tag;

    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [OPC_W-1:0]    alu_opcode;
    logic [DATA_W-1:0]   alu_result;
    logic [FLG_W-1:0]    alu_ovf;
    logic [FLG_W-1:0]    alu_udf;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [TAG_W-1:0]    rsp_tag;
    logic [DATA_W-1:0]   rsp_result;
    logic [FLG_W-1:0]    rsp_ovf;
    logic [FLG_W-1:0]    rsp_udf;
    logic                rsp_err;
    logic                busy;

    modport slave (
        input  req_valid, req_a, req_b, req_opcode, req_tag,
        input  alu_result, alu_ovf, alu_udf, rsp_ready,
        output req_ready, alu_a, alu_b, alu_opcode,
        output rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_ovf, rsp_udf, rsp_err, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_opcode, req_tag,
        output alu_result, alu_ovf, alu_udf, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_opcode,
        input  rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_ovf, rsp_udf, rsp_err, busy
    );
endinterface

// File: rtl/simd_alu_req_sched.sv
// Round-robin share of one SIMD adder between two requesters; response valid ALU_LAT+1 cycles after accept.
// Backpressure: credits (in-flight + queued) cap issue at RSP_DEPTH, so the response FIFO never overflows.
module simd_alu_req_sched #(
    parameter int DATA_W    = 256,
    parameter int OPC_W     = 4,
    parameter int TAG_W     = 4,
    parameter int ALU_LAT   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    simd_alu_req_sched_if.slave bus
);
    localparam int FLG_W = DATA_W / 8;
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             id;
        logic [TAG_W-1:0] tag;
        logic             err;
    } meta_t;

    typedef struct packed {
        meta_t             meta;
        logic [DATA_W-1:0] result;
        logic [FLG_W-1:0]  ovf;
        logic [FLG_W-1:0]  udf;
    } rsp_t;

    function automatic logic op_is_add(input logic [OPC_W-1:0] opc);
        return ({1'b0, opc} < (OPC_W+1)'(8));
    endfunction

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q;
    logic [1:0]        gnt;
    logic              gnt_id;
    logic              issue;
    logic              pop;
    logic              push;

    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [OPC_W-1:0]  alu_opc_q;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [OPC_W-1:0]  sel_opc;
    meta_t             issue_meta;

    logic [ALU_LAT-1:0] pipe_vld_q;
    meta_t              pipe_q [ALU_LAT];

    logic [PTR_W:0]    wr_q, rd_q;
    rsp_t              mem_q [RSP_DEPTH];
    rsp_t              push_ent;
    rsp_t              head;

    // Grant is purely combinational; a pop in this cycle does not free a credit until the next one.
    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        if (cnt_q < CNT_W'(RSP_DEPTH)) begin
            if (bus.req_valid == 2'b11) begin
                gnt_id = ~last_q;
                gnt    = last_q ? 2'b01 : 2'b10;
            end else if (bus.req_valid[0]) begin
                gnt    = 2'b01;
            end else if (bus.req_valid[1]) begin
                gnt_id = 1'b1;
                gnt    = 2'b10;
            end
        end
    end

    assign issue         = |gnt;
    assign bus.req_ready = gnt;

    assign sel_a   = gnt_id ? bus.req_a[2*DATA_W-1:DATA_W]    : bus.req_a[DATA_W-1:0];
    assign sel_b   = gnt_id ? bus.req_b[2*DATA_W-1:DATA_W]    : bus.req_b[DATA_W-1:0];
    assign sel_opc = gnt_id ? bus.req_opcode[2*OPC_W-1:OPC_W] : bus.req_opcode[OPC_W-1:0];

    always_comb begin
        issue_meta     = '0;
        issue_meta.id  = gnt_id;
        issue_meta.tag = gnt_id ? bus.req_tag[2*TAG_W-1:TAG_W] : bus.req_tag[TAG_W-1:0];
        issue_meta.err = ~op_is_add(sel_opc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_opc_q <= '0;
        end else if (issue) begin
            alu_a_q   <= sel_a;
            alu_b_q   <= sel_b;
            alu_opc_q <= sel_opc;
        end
    end

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_opc_q;

    // Tag pipe mirrors the ALU latency so the last stage lines up with the edge that samples the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < ALU_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_vld_q[0] <= issue;
            pipe_q[0]     <= issue_meta;
            for (int i = 1; i < ALU_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_q[i]     <= pipe_q[i-1];
            end
        end
    end

    assign push = pipe_vld_q[ALU_LAT-1];

    always_comb begin
        push_ent      = '0;
        push_ent.meta = pipe_q[ALU_LAT-1];
        if (!pipe_q[ALU_LAT-1].err) begin
            push_ent.result = bus.alu_result;
            push_ent.ovf    = bus.alu_ovf;
            push_ent.udf    = bus.alu_udf;
        end
    end

    assign bus.rsp_valid = (wr_q != rd_q);
    assign pop           = bus.rsp_valid & bus.rsp_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (issue && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!issue && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= 1'b1;
        end else begin
            if (push)  wr_q   <= wr_q + 1'b1;
            if (pop)   rd_q   <= rd_q + 1'b1;
            if (issue) last_q <= gnt_id;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[PTR_W-1:0]] <= push_ent;
    end

    assign head           = mem_q[rd_q[PTR_W-1:0]];
    assign bus.rsp_id     = head.meta.id;
    assign bus.rsp_tag    = head.meta.tag;
    assign bus.rsp_err    = head.meta.err;
    assign bus.rsp_result = head.result;
    assign bus.rsp_ovf    = head.ovf;
    assign bus.rsp_udf    = head.udf;
    assign bus.busy       = (cnt_q != '0);
endmodule

// File: tb/tb_simd_alu_req_sched.sv
// Bench for simd_alu_req_sched: randomized requests against a credit/queue reference model.
`timescale 1ns/1ps
module tb_simd_alu_req_sched;
    localparam int DW    = 256;
    localparam int OW    = 4;
    localparam int TW    = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int FW    = DW / 8;

    typedef struct packed {
        logic          id;
        logic [TW-1:0] tag;
        logic          err;
        logic [DW-1:0] result;
        logic [FW-1:0] ovf;
        logic [FW-1:0] udf;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simd_alu_req_sched_if #(.DATA_W(DW), .OPC_W(OW), .TAG_W(TW)) bus ();

    simd_alu_req_sched #(
        .DATA_W(DW), .OPC_W(OW), .TAG_W(TW), .ALU_LAT(LAT), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ALU stand-in: opcode bit 0 selects per-byte subtract (borrow -> udf), else per-byte add (carry -> ovf).
    function automatic logic [DW+2*FW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                 input logic [OW-1:0] opc);
        logic [DW-1:0] r;
        logic [FW-1:0] o, u;
        logic [8:0]    s;
        r = '0; o = '0; u = '0;
        for (int i = 0; i < FW; i++) begin
            if (opc[0]) begin
                s = {1'b0, a[i*8 +: 8]} - {1'b0, b[i*8 +: 8]};
                u[i] = s[8];
            end else begin
                s = {1'b0, a[i*8 +: 8]} + {1'b0, b[i*8 +: 8]};
                o[i] = s[8];
            end
            r[i*8 +: 8] = s[7:0];
        end
        return {r, o, u};
    endfunction

    logic [DW+2*FW-1:0] alu_stage;
    always @(posedge clk) alu_stage <= alu_f(bus.alu_a, bus.alu_b, bus.alu_opcode);
    assign {bus.alu_result, bus.alu_ovf, bus.alu_udf} = alu_stage;

    function automatic rec_t model_rsp(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                       input logic [OW-1:0] opc, input logic [TW-1:0] tag);
        rec_t m;
        m.id  = id;
        m.tag = tag;
        m.err = (opc > 4'd7);
        if (m.err) {m.result, m.ovf, m.udf} = '0;
        else       {m.result, m.ovf, m.udf} = alu_f(a, b, opc);
        return m;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [OW-1:0] opc, input logic [TW-1:0] tag);
        bus.req_a[i*DW +: DW]      = a;
        bus.req_b[i*DW +: DW]      = b;
        bus.req_opcode[i*OW +: OW] = opc;
        bus.req_tag[i*TW +: TW]    = tag;
    endtask

    task automatic rnd_req(input int i);
        set_req(i, rnd_word(), rnd_word(), OW'($urandom_range(0, 7)), TW'($urandom));
    endtask

    // Reference model state: outstanding credits, rr pointer, due cycles of queued responses.
    int   total = 0, bad = 0;
    int   cyc = 0, m_cnt = 0;
    logic m_last = 1'b1;
    int   avail_q[$];
    int   acc_log[$];
    rec_t exp_q[$];
    rec_t got_q[$];
    bit   auto_pl = 1'b0;
    logic [1:0] e_rdy, o_rdy;
    logic e_vld, o_vld, e_busy, o_busy;
    rec_t o_rsp;

    task automatic tick();
        logic [1:0] acc;
        acc = 2'b00;
        @(negedge clk);
        o_rdy  = bus.req_ready;
        o_vld  = bus.rsp_valid;
        o_busy = bus.busy;
        o_rsp  = {bus.rsp_id, bus.rsp_tag, bus.rsp_err, bus.rsp_result, bus.rsp_ovf, bus.rsp_udf};
        e_rdy  = 2'b00;
        if (m_cnt < DEPTH) begin
            if (bus.req_valid == 2'b11) e_rdy = m_last ? 2'b01 : 2'b10;
            else                        e_rdy = bus.req_valid;
        end
        e_vld  = (avail_q.size() > 0) && (avail_q[0] <= cyc);
        e_busy = (m_cnt != 0);
        if (rst) begin
            m_cnt  = 0;
            m_last = 1'b1;
            avail_q.delete();
            exp_q.delete();
            got_q.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (bus.req_valid[i] && o_rdy[i]) begin
                    exp_q.push_back(model_rsp(1'(i), bus.req_a[i*DW +: DW], bus.req_b[i*DW +: DW],
                                              bus.req_opcode[i*OW +: OW], bus.req_tag[i*TW +: TW]));
                    avail_q.push_back(cyc + LAT + 1);
                    acc_log.push_back(i);
                    m_last = 1'(i);
                    m_cnt++;
                    acc[i] = 1'b1;
                end
            end
            if (o_vld && bus.rsp_ready) begin
                got_q.push_back(o_rsp);
                if (avail_q.size() > 0) void'(avail_q.pop_front());
                m_cnt--;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (auto_pl) begin
            for (int i = 0; i < 2; i++) if (acc[i]) rnd_req(i);
        end
    endtask

    task automatic drain(output bit timed_out);
        int n;
        n = 0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        while (m_cnt > 0 && n < 60) begin
            tick();
            n++;
        end
        for (int i = 0; i < 4; i++) tick();
        timed_out = (m_cnt != 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        rnd_req(0);
        rnd_req(1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b want=0", bus.rsp_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
        total++; if (bus.alu_a !== '0) begin bad++; $display("FAIL reset_alu_a got=%h want=0", bus.alu_a); end
        total++; if (bus.alu_opcode !== '0) begin bad++; $display("FAIL reset_alu_opcode got=%h want=0", bus.alu_opcode); end
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", bus.req_ready); end
    endtask

    task automatic test_single();
        rec_t want;
        want = {1'b0, 4'd3, 1'b0, {DW{1'b0}}, {FW{1'b1}}, {FW{1'b0}}};
        auto_pl = 1'b0;
        bus.rsp_ready = 1'b1;
        set_req(0, {32{8'hFF}}, {32{8'h01}}, 4'h0, 4'd3);
        bus.req_valid = 2'b01;
        #1;
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b want=01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        for (int n = 1; n <= 3; n++) begin
            tick();
            total++; if (o_vld !== (n == 3)) begin bad++; $display("FAIL single_latency cycle=%0d got=%0b want=%0b", n, o_vld, (n == 3)); end
        end
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", got_q.size()); end
        total++; if (got_q.size() < 1 || got_q[0] !== want) begin bad++; $display("FAIL single_rsp got=%h want=%h", o_rsp, want); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int  a0;
        bit  to;
        auto_pl = 1'b1;
        rnd_req(0);
        rnd_req(1);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        a0 = acc_log.size();
        for (int c = 0; c < 24; c++) begin
            tick();
            total++; if (o_rdy !== e_rdy) begin bad++; $display("FAIL b2b_grant cycle=%0d got=%b want=%b", c, o_rdy, e_rdy); end
            total++; if (o_vld !== e_vld) begin bad++; $display("FAIL b2b_rsp_valid cycle=%0d got=%0b want=%0b", c, o_vld, e_vld); end
        end
        total++; if (acc_log.size() - a0 != 24) begin bad++; $display("FAIL b2b_rate got=%0d want=24", acc_log.size() - a0); end
        for (int k = a0 + 1; k < acc_log.size(); k++) begin
            total++; if (acc_log[k] == acc_log[k-1]) begin bad++; $display("FAIL b2b_alternate idx=%0d got=%0d want=%0d", k, acc_log[k], 1 - acc_log[k-1]); end
        end
        drain(to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL b2b_drain_timeout got=%0d want=0 outstanding", m_cnt); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            rec_t g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL b2b_rsp got=%h want=%h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_credit();
        int a0;
        bit to;
        auto_pl = 1'b1;
        rnd_req(0);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b01;
        a0 = acc_log.size();
        for (int c = 0; c < 10; c++) begin
            tick();
            total++; if (o_rdy !== e_rdy) begin bad++; $display("FAIL credit_grant cycle=%0d got=%b want=%b", c, o_rdy, e_rdy); end
        end
        total++; if (acc_log.size() - a0 != 4) begin bad++; $display("FAIL credit_accepts got=%0d want=4", acc_log.size() - a0); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL credit_busy got=%0b want=1", o_busy); end
        total++; if (o_rdy !== 2'b00) begin bad++; $display("FAIL credit_stall got=%b want=00", o_rdy); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        total++; if (o_rdy !== 2'b00) begin bad++; $display("FAIL credit_no_bypass got=%b want=00", o_rdy); end
        tick();
        total++; if (o_rdy !== 2'b01) begin bad++; $display("FAIL credit_refill got=%b want=01", o_rdy); end
        tick();
        tick();
        total++; if (acc_log.size() - a0 != 5) begin bad++; $display("FAIL credit_accepts_after_pop got=%0d want=5", acc_log.size() - a0); end
        drain(to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL credit_drain_timeout got=%0d want=0 outstanding", m_cnt); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL credit_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            rec_t g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL credit_rsp got=%h want=%h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_err();
        rec_t want;
        bit   to;
        want = {1'b1, 4'd9, 1'b1, {DW{1'b0}}, {FW{1'b0}}, {FW{1'b0}}};
        auto_pl = 1'b0;
        bus.rsp_ready = 1'b1;
        rnd_req(0);
        set_req(1, rnd_word(), rnd_word(), 4'hF, 4'd9);
        bus.req_valid = 2'b01;
        tick();
        total++; if (o_rdy !== e_rdy) begin bad++; $display("FAIL err_grant0 got=%b want=%b", o_rdy, e_rdy); end
        rnd_req(0);
        bus.req_valid = 2'b11;
        tick();
        total++; if (o_rdy !== e_rdy) begin bad++; $display("FAIL err_grant1 got=%b want=%b", o_rdy, e_rdy); end
        bus.req_valid = 2'b01;
        tick();
        total++; if (o_rdy !== e_rdy) begin bad++; $display("FAIL err_grant2 got=%b want=%b", o_rdy, e_rdy); end
        drain(to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL err_drain_timeout got=%0d want=0 outstanding", m_cnt); end
        total++; if (got_q.size() != 3) begin bad++; $display("FAIL err_count got=%0d want=3", got_q.size()); end
        total++; if (got_q.size() < 3 || got_q[1] !== want) begin bad++; $display("FAIL err_rsp got=%h want=%h", (got_q.size() > 1) ? got_q[1] : '0, want); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            rec_t g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL err_order got=%h want=%h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit to;
        auto_pl = 1'b1;
        bus.rsp_ready = 1'b0;
        rnd_req(0);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        for (int c = 0; c < 4; c++) tick();
        total++; if (o_vld !== 1'b1) begin bad++; $display("FAIL rmid_fifo_loaded got=%0b want=1", o_vld); end
        bus.req_valid = 2'b01;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 2'b00;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_rsp_valid got=%0b want=0", bus.rsp_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b want=0", bus.busy); end
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++; if (o_vld !== e_vld) begin bad++; $display("FAIL rmid_stale cycle=%0d got=%0b want=%0b", c, o_vld, e_vld); end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL rmid_no_rsp got=%0d want=0", got_q.size()); end
        bus.req_valid = 2'b11;
        #1;
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rmid_first_grant got=%b want=01", bus.req_ready); end
        tick();
        drain(to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL rmid_drain_timeout got=%0d want=0 outstanding", m_cnt); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            rec_t g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL rmid_rsp got=%h want=%h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_hold_full();
        rec_t snap;
        bit   to;
        auto_pl = 1'b1;
        bus.rsp_ready = 1'b0;
        rnd_req(0);
        bus.req_valid = 2'b01;
        for (int c = 0; c < 4; c++) tick();
        bus.req_valid = 2'b00;
        for (int c = 0; c < 3; c++) tick();
        total++; if (o_vld !== 1'b1) begin bad++; $display("FAIL hold_pending got=%0b want=1", o_vld); end
        snap = o_rsp;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++; if (o_rsp !== snap || o_vld !== 1'b1) begin bad++; $display("FAIL hold_stable cycle=%0d got=%h want=%h", c, o_rsp, snap); end
        end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL hold_busy got=%0b want=1", o_busy); end
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL hold_full_no_issue got=%b want=00", bus.req_ready); end
        tick();
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL hold_issue_after_pop got=%b want=01", bus.req_ready); end
        tick();
        drain(to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL hold_drain_timeout got=%0d want=0 outstanding", m_cnt); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL hold_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            rec_t g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL hold_rsp got=%h want=%h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bus.req_valid  = 2'b00;
        bus.rsp_ready  = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_opcode = '0;
        bus.req_tag    = '0;
        rst            = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_credit();
        test_err();
        test_reset_mid();
        test_hold_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
